led_seq_ctrl: RTL and testbench
===============================

# led_seq_ctrl

Sequencing controller for the board's three active-low RGB LEDs, driven from the 24 MHz crystal clock. Synchronises and debounces the two active-low push buttons, uses BTN_A to select a display mode and BTN_B to select a step rate, and generates a prescaled step tick that advances the LED pattern. Sits between the raw button/LED pins and replaces the free-running counter that drove the LEDs directly.

## Interface

- DEBOUNCE_CYCLES, 240000, consecutive stable cycles before a button level is accepted (10 ms at 24 MHz); minimum 2
- TICK_DIV, 6000000, base step period in clock cycles at RATE=0 (4 Hz); power of two ≥ 8 not required, but TICK_DIV>>3 must be ≥ 1
- XTAL_IN  input  1  clock, 24 MHz, all logic on rising edge
- RST_N  input  1  reset, asynchronous assert, active-low
- BTN_A  input  1  mode button, raw pin, active-low, asynchronous to XTAL_IN
- BTN_B  input  1  rate button, raw pin, active-low, asynchronous to XTAL_IN
- LED_R  output  1  red LED, active-low, registered
- LED_G  output  1  green LED, active-low, registered
- LED_B  output  1  blue LED, active-low, registered
- MODE  output  2  current mode: 0 OFF, 1 BLINK, 2 CHASE, 3 BINARY
- RATE  output  2  current rate select 0..3

## Operation

- Button path (per button): 2-flop synchroniser -> s; debounced level db (reset 1 = released); counter cnt (reset 0).
  - s == db: cnt <= 0.
  - s != db and cnt == DEBOUNCE_CYCLES-1: db <= s, cnt <= 0.
  - otherwise cnt <= cnt+1.
  - Press event: db transitions 1->0. Release produces no event.
- MODE register: on BTN_A press event MODE <= MODE+1, wrapping 3->0.
- RATE register: on BTN_B press event RATE <= RATE+1, wrapping 3->0.
- Both events in same cycle: both registers update; neither is lost.
- Prescaler: counts 0..(TICK_DIV>>RATE)-1; tick asserted for one cycle at terminal count, counter returns to 0.
- Step counter (3 bits): advances on tick. In CHASE it wraps 2->0, otherwise 7->0.
- Any MODE change or RATE change clears prescaler and step to 0 in the same cycle as the register update.
- Pattern P = {R,G,B}, active-high; LEDs = ~P:
  - OFF: P = 000.
  - BLINK: P = step[0] ? 111 : 000.
  - CHASE: step 0 -> 100, 1 -> 010, 2 -> 001.
  - BINARY: R = step[0], G = step[1], B = step[2].
- Reset values: MODE 0, RATE 0, prescaler 0, step 0, db 1 for both buttons, LED_R/G/B 1 (all off). Applied asynchronously, including mid-debounce and mid-tick; first activity resumes on the first edge after RST_N rises.

## Timing

- Button level change to db change: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles of stable s.
- db fall -> MODE/RATE update: 1 cycle.
- MODE/RATE/step update -> LED pins: 1 cycle (LEDs registered from current state).
- Step period at RATE r: exactly TICK_DIV>>r cycles; first tick after a clear occurs TICK_DIV>>r cycles later.
- Bounce shorter than DEBOUNCE_CYCLES: no event, cnt returns to 0 on first sample equal to db.
- Holding a button: exactly one event per press; no auto-repeat.

## Test plan

Use DEBOUNCE_CYCLES=4, TICK_DIV=16.

- Reset: run in BINARY, assert RST_N low between edges -> LED_R/G/B = 1, MODE=0, RATE=0 immediately; after release LEDs stay 1 in OFF.
- Debounce: BTN_A low 3 cycles then high -> MODE stays 0; BTN_A low 10 cycles -> MODE=1 exactly once; release -> MODE unchanged.
- BLINK, RATE 0: LEDs all 0 for 16 cycles, all 1 for 16 cycles, repeating; period 32 cycles.
- Rate cycling: three BTN_B presses -> RATE=3, BLINK half-period 2 cycles; fourth press -> RATE=0; each press restarts pattern from step 0.
- CHASE then BINARY: CHASE gives LED_R low, LED_G low, LED_B low in turn, each 16 cycles, repeating; BINARY shows step 0..7 with LED_R = ~step[0], wraps to 000 after 8 ticks.
- Simultaneous: BTN_A and BTN_B pressed in same cycle from MODE=1, RATE=1 -> MODE=2 and RATE=2 on same edge, step and prescaler cleared.

Source files
------------

// File: rtl/led_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl_if
//
// Pin-level bundle between the board's buttons/LEDs and led_seq_ctrl.
// There is no valid/ready handshake on this bundle. Every signal is a plain
// level. The buttons are raw asynchronous pins, and the controller
// synchronises them internally. The LED, MODE and RATE outputs are
// registered levels that may be sampled on any cycle.
//
// Signals
//   BTN_A  mode button, raw pin, active-low
//   BTN_B  rate button, raw pin, active-low
//   LED_R  red LED, active-low
//   LED_G  green LED, active-low
//   LED_B  blue LED, active-low
//   MODE   current display mode (0 OFF, 1 BLINK, 2 CHASE, 3 BINARY)
//   RATE   current step-rate select (0..3)
//
// Modports
//   master  board/pin side: drives the buttons, observes the outputs
//   slave   controller side: reads the buttons, drives the outputs
// ---------------------------------------------------------------------------
interface led_seq_ctrl_if;
    logic       BTN_A;
    logic       BTN_B;
    logic       LED_R;
    logic       LED_G;
    logic       LED_B;
    logic [1:0] MODE;
    logic [1:0] RATE;

    modport master (
        output BTN_A,
        output BTN_B,
        input  LED_R,
        input  LED_G,
        input  LED_B,
        input  MODE,
        input  RATE
    );

    modport slave (
        input  BTN_A,
        input  BTN_B,
        output LED_R,
        output LED_G,
        output LED_B,
        output MODE,
        output RATE
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl
//
// Sequencing controller for three active-low RGB LEDs. The two raw
// active-low buttons are synchronised and debounced. A press of BTN_A steps
// the display mode, and a press of BTN_B steps the rate. A prescaler
// produces a step tick whose period is TICK_DIV >> RATE cycles. The tick
// advances a 3-bit step counter, and the current mode maps that step onto
// the LED pattern.
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronised cycles before a level is accepted (>= 2)
//   TICK_DIV         step period in cycles at RATE 0 (TICK_DIV>>3 must be >= 1)
//
// Ports
//   XTAL_IN  clock, all logic on the rising edge
//   RST_N    asynchronous active-low reset
//   pins     led_seq_ctrl_if.slave (BTN_A/BTN_B in; LED_R/G/B, MODE, RATE out)
// ---------------------------------------------------------------------------
module led_seq_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 240000,
    parameter int unsigned TICK_DIV        = 6000000
) (
    input  logic           XTAL_IN,
    input  logic           RST_N,
    led_seq_ctrl_if.slave  pins
);

    // Counter widths. The debounce counter peaks at DEBOUNCE_CYCLES-1, and
    // the prescaler peaks at TICK_DIV-1.
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [PS_W-1:0] PS_LAST_R0 = PS_W'((TICK_DIV >> 0) - 1);
    localparam logic [PS_W-1:0] PS_LAST_R1 = PS_W'((TICK_DIV >> 1) - 1);
    localparam logic [PS_W-1:0] PS_LAST_R2 = PS_W'((TICK_DIV >> 2) - 1);
    localparam logic [PS_W-1:0] PS_LAST_R3 = PS_W'((TICK_DIV >> 3) - 1);

    // Display modes. The mode register is the only state the pattern logic
    // keys on, and it is visible on pins.MODE.
    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_CHASE  = 2'd2;
    localparam logic [1:0] MODE_BINARY = 2'd3;

    // ------------------------------------------------------------------
    // Button path. Index 0 is BTN_A and index 1 is BTN_B.
    // ------------------------------------------------------------------
    logic [1:0]      btn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      db;
    logic [1:0]      db_q;
    logic [DB_W-1:0] cnt [2];
    logic            press_a;
    logic            press_b;

    assign btn_raw = {pins.BTN_B, pins.BTN_A};

    // The synchroniser resets to the released level. A button held through
    // reset therefore has to be re-qualified before it counts as a press.
    always_ff @(posedge XTAL_IN or negedge RST_N) begin
        if (!RST_N) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            db     <= 2'b11;
            db_q   <= 2'b11;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            db_q  <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    // A bounce back to the accepted level restarts qualification.
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is a 1->0 edge of the debounced level. A release produces no
    // event, and holding a button yields exactly one pulse.
    assign press_a = db_q[0] & ~db[0];
    assign press_b = db_q[1] & ~db[1];

    // ------------------------------------------------------------------
    // Mode/rate registers, prescaler and step counter
    // ------------------------------------------------------------------
    logic [1:0]      mode;
    logic [1:0]      rate;
    logic [PS_W-1:0] presc;
    logic [PS_W-1:0] presc_last;
    logic [2:0]      step;
    logic            tick;
    logic            step_last;
    logic            sel_change;

    always_comb begin
        presc_last = PS_LAST_R0;
        case (rate)
            2'd0:    presc_last = PS_LAST_R0;
            2'd1:    presc_last = PS_LAST_R1;
            2'd2:    presc_last = PS_LAST_R2;
            default: presc_last = PS_LAST_R3;
        endcase
    end

    assign tick       = (presc == presc_last);
    // CHASE has only three lit positions. Every other mode uses all eight steps.
    assign step_last  = (mode == MODE_CHASE) ? (step == 3'd2) : (step == 3'd7);
    assign sel_change = press_a | press_b;

    // Both buttons may produce their events on the same cycle. Each register
    // updates independently, so neither press is lost. Any change restarts
    // the pattern from step 0, with a full step period before the first tick.
    always_ff @(posedge XTAL_IN or negedge RST_N) begin
        if (!RST_N) begin
            mode  <= MODE_OFF;
            rate  <= 2'd0;
            presc <= '0;
            step  <= 3'd0;
        end else begin
            if (press_a) begin
                mode <= mode + 2'd1;
            end
            if (press_b) begin
                rate <= rate + 2'd1;
            end
            if (sel_change) begin
                presc <= '0;
                step  <= 3'd0;
            end else if (tick) begin
                presc <= '0;
                step  <= step_last ? 3'd0 : step + 3'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pattern decode, with pattern = {R,G,B} active-high
    // ------------------------------------------------------------------
    logic [2:0] pattern;
    logic [2:0] led_n;

    always_comb begin
        pattern = 3'b000;
        case (mode)
            MODE_OFF:   pattern = 3'b000;
            MODE_BLINK: pattern = step[0] ? 3'b111 : 3'b000;
            MODE_CHASE: begin
                if (step == 3'd0) begin
                    pattern = 3'b100;
                end else if (step == 3'd1) begin
                    pattern = 3'b010;
                end else begin
                    pattern = 3'b001;
                end
            end
            MODE_BINARY: pattern = {step[0], step[1], step[2]};
            default:     pattern = 3'b000;
        endcase
    end

    // The LED pins are registered from the current mode/step. They therefore
    // lag a state update by one cycle and are glitch-free at the pins.
    always_ff @(posedge XTAL_IN or negedge RST_N) begin
        if (!RST_N) begin
            led_n <= 3'b111;
        end else begin
            led_n <= ~pattern;
        end
    end

    assign pins.LED_R = led_n[2];
    assign pins.LED_G = led_n[1];
    assign pins.LED_B = led_n[0];
    assign pins.MODE  = mode;
    assign pins.RATE  = rate;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_seq_ctrl
//
// Bench for led_seq_ctrl with DEBOUNCE_CYCLES=4 and TICK_DIV=16. A reference
// model computes the expected outputs after each rising edge and queues them.
// A monitor pops one entry per falling edge and compares it with the pins.
// The model is written from the behavioural rules:
//   - a level is accepted once the last DEB synchronised samples all differ
//     from the accepted level;
//   - the step equals (cycles since last clear / period) mod the wrap length.
// ---------------------------------------------------------------------------
module tb_led_seq_ctrl;

    localparam int DEB = 4;
    localparam int DIV = 16;
    localparam int W   = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    led_seq_ctrl_if pins ();

    led_seq_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV       (DIV)
    ) dut (
        .XTAL_IN(clk),
        .RST_N  (rst_n),
        .pins   (pins)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- reference model state ----------------
    int         m_n     = 0;
    int         m_clear = 0;
    logic [1:0] m_mode  = 2'd0;
    logic [1:0] m_rate  = 2'd0;
    logic [1:0] m_r1    = 2'b11;
    logic [1:0] m_r2    = 2'b11;
    logic [1:0] m_db    = 2'b11;
    logic [1:0] m_pend  = 2'b00;
    logic [1:0] m_hist [DEB];

    function automatic logic [2:0] pattern(input logic [1:0] md, input int st);
        logic [2:0] b;
        b = 3'(st);
        case (md)
            2'd0:    return 3'b000;
            2'd1:    return b[0] ? 3'b111 : 3'b000;
            2'd2:    return (st == 0) ? 3'b100 : ((st == 1) ? 3'b010 : 3'b001);
            default: return {b[0], b[1], b[2]};
        endcase
    endfunction

    function automatic int step_at(input int m);
        int span;
        span = DIV >> m_rate;
        return ((m - m_clear) / span) % ((m_mode == 2'd2) ? 3 : 8);
    endfunction

    // Model: one expected output word per rising edge.
    initial begin : model
        logic [2:0] led;
        logic [1:0] s;
        logic [1:0] new_pend;
        logic       all_diff;
        for (int i = 0; i < DEB; i++) m_hist[i] = 2'b11;
        forever begin
            @(posedge clk);
            m_n++;
            if (!rst_n) begin
                m_mode  = 2'd0;
                m_rate  = 2'd0;
                m_clear = m_n;
                m_r1    = 2'b11;
                m_r2    = 2'b11;
                m_db    = 2'b11;
                m_pend  = 2'b00;
                for (int i = 0; i < DEB; i++) m_hist[i] = 2'b11;
                exp_q.push_back({3'b111, 2'd0, 2'd0});
            end else begin
                led = ~pattern(m_mode, step_at(m_n - 1));
                if (m_pend[0]) m_mode = m_mode + 2'd1;
                if (m_pend[1]) m_rate = m_rate + 2'd1;
                if (m_pend != 2'b00) m_clear = m_n;
                s = m_r2;
                for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = s;
                new_pend = 2'b00;
                for (int b = 0; b < 2; b++) begin
                    all_diff = 1'b1;
                    for (int i = 0; i < DEB; i++)
                        if (m_hist[i][b] == m_db[b]) all_diff = 1'b0;
                    if (all_diff) begin
                        if (m_db[b]) new_pend[b] = 1'b1;
                        m_db[b] = ~m_db[b];
                    end
                end
                m_pend = new_pend;
                m_r2   = m_r1;
                m_r1   = {pins.BTN_B, pins.BTN_A};
                exp_q.push_back({led, m_mode, m_rate});
            end
        end
    end

    // Monitor: compare each falling edge against the oldest expectation.
    initial begin : monitor
        logic [W-1:0] e;
        logic [W-1:0] a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pins.LED_R, pins.LED_G, pins.LED_B, pins.MODE, pins.RATE};
                n_vec++;
                if (a !== e) begin
                    n_miss++;
                    $display("FAIL outputs t=%0t got led=%b mode=%0d rate=%0d, want led=%b mode=%0d rate=%0d",
                             $time, a[6:4], a[3:2], a[1:0], e[6:4], e[3:2], e[1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic a, input logic b, input int hold, input int settle);
        @(negedge clk);
        if (a) pins.BTN_A = 1'b0;
        if (b) pins.BTN_B = 1'b0;
        repeat (hold) @(negedge clk);
        pins.BTN_A = 1'b1;
        pins.BTN_B = 1'b1;
        repeat (settle) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int ha;
        pins.BTN_A = 1'b1;
        pins.BTN_B = 1'b1;
        rst_n      = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(4);

        // A bounce shorter than the debounce window must be ignored.
        press(1'b1, 1'b0, 3, 12);
        #1 check("bounce_mode", pins.MODE, 0);
        // A long press gives exactly one event.
        press(1'b1, 1'b0, 10, 12);
        #1 check("long_press_mode", pins.MODE, 1);
        cycles(70);

        // Rate cycling in BLINK mode.
        for (int i = 0; i < 3; i++) begin
            press(1'b0, 1'b1, 6, 12);
            cycles(20);
        end
        #1 check("rate_after_3", pins.RATE, 3);
        press(1'b0, 1'b1, 6, 12);
        #1 check("rate_wrap", pins.RATE, 0);
        cycles(40);

        // CHASE mode, then BINARY mode through a full wrap.
        press(1'b1, 1'b0, 6, 12);
        cycles(60);
        press(1'b1, 1'b0, 6, 12);
        #1 check("mode_binary", pins.MODE, 3);
        cycles(140);

        // Asynchronous reset asserted between clock edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_leds", {pins.LED_R, pins.LED_G, pins.LED_B}, 7);
        check("rst_mode", pins.MODE, 0);
        check("rst_rate", pins.RATE, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(20);

        // Simultaneous presses starting from MODE=1, RATE=1.
        press(1'b1, 1'b0, 6, 12);
        press(1'b0, 1'b1, 6, 12);
        #1 check("pre_sim_mode", pins.MODE, 1);
        check("pre_sim_rate", pins.RATE, 1);
        press(1'b1, 1'b1, 6, 12);
        #1 check("sim_mode", pins.MODE, 2);
        check("sim_rate", pins.RATE, 2);
        cycles(30);

        // Randomised button levels, with occasional mid-run resets.
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            pins.BTN_A = 1'($urandom_range(0, 1));
            pins.BTN_B = 1'($urandom_range(0, 1));
            ha = $urandom_range(1, 6);
            repeat (ha - 1) @(negedge clk);
        end
        @(negedge clk);
        pins.BTN_A = 1'b1;
        pins.BTN_B = 1'b1;
        cycles(40);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
